// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// Each accepted bit is compared, together with the previous PATTERN_W-1
// accepted bits, against a run-time loadable pattern. A match gives a
// registered one-cycle pulse and bumps a saturating match counter.
// Detection can be overlapping or non-overlapping, chosen per cycle.
module seq_detector_param #(
    parameter int unsigned          PATTERN_W     = 4,
    parameter logic [PATTERN_W-1:0] RESET_PATTERN = 4'b1011,
    parameter int unsigned          CNT_W         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sequence_in,
    input  logic                 valid_in,
    input  logic                 overlap_en,
    input  logic                 pattern_load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic                 count_clear,
    output logic                 detector_out,
    output logic [CNT_W-1:0]     match_count,
    output logic                 count_sat,
    output logic [PATTERN_W-1:0] pattern_out
);

    localparam int unsigned          FILL_W   = $clog2(PATTERN_W);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    logic [PATTERN_W-2:0] hist_q,    hist_d;
    logic [FILL_W-1:0]    fill_q,    fill_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic                 sat_q,     sat_d;
    logic                 det_q,     det_d;

    logic                 accept;
    logic [PATTERN_W-1:0] window;
    logic                 match;

    // A load takes priority: a bit presented on the load edge is dropped.
    assign accept = valid_in && !pattern_load;
    // The newest bit sits in the LSB; the oldest history bit in the MSB.
    assign window = {hist_q, sequence_in};
    // A match needs a full window of bits accepted since the last fill clear.
    assign match  = accept && (window == pattern_q) && (fill_q == FILL_MAX);

    // Next-state logic for history, fill level, pattern and match counter.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves it unassigned, which would infer a latch.
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        count_d   = count_q;

        if (pattern_load) begin
            pattern_d = pattern_in;
            fill_d    = '0;
        end else if (accept) begin
            hist_d = window[PATTERN_W-2:0];
            if (match && !overlap_en) begin
                // Matched bits are consumed and cannot seed the next match.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (count_clear) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end

        sat_d = (count_d == CNT_MAX);
        det_d = match;
    end

    // State registers; reset discards any partial match in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RESET_PATTERN;
            count_q   <= '0;
            sat_q     <= 1'b0;
            det_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            det_q     <= det_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = count_q;
    assign count_sat    = sat_q;
    assign pattern_out  = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: a directed vector table on the
// default 4-bit instance, hand sequences for saturation and asynchronous
// reset, and an 8-bit instance checked against a reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sequence_in, valid_in, overlap_en, pattern_load, count_clear;
    logic [3:0] pattern_in;
    logic [7:0] pattern_in_c;

    logic       a_det, a_sat;
    logic [7:0] a_cnt;
    logic [3:0] a_pat;
    logic       b_det, b_sat;
    logic [1:0] b_cnt;
    logic [3:0] b_pat;
    logic       c_det, c_sat;
    logic [7:0] c_cnt;
    logic [7:0] c_pat;

    seq_detector_param dut_a (
        .clock(clk), .reset(rst_n), .sequence_in(sequence_in), .valid_in(valid_in),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .detector_out(a_det), .match_count(a_cnt),
        .count_sat(a_sat), .pattern_out(a_pat)
    );

    seq_detector_param #(.PATTERN_W(4), .RESET_PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clock(clk), .reset(rst_n), .sequence_in(sequence_in), .valid_in(valid_in),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .detector_out(b_det), .match_count(b_cnt),
        .count_sat(b_sat), .pattern_out(b_pat)
    );

    seq_detector_param #(.PATTERN_W(8), .RESET_PATTERN(8'hA5), .CNT_W(8)) dut_c (
        .clock(clk), .reset(rst_n), .sequence_in(sequence_in), .valid_in(valid_in),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in_c),
        .count_clear(count_clear), .detector_out(c_det), .match_count(c_cnt),
        .count_sat(c_sat), .pattern_out(c_pat)
    );

    typedef struct {
        logic       valid;
        logic       seq;
        logic       ovl;
        logic       load;
        logic [3:0] pat;
        logic       clr;
        logic       e_det;
        logic [7:0] e_cnt;
        logic [3:0] e_pat;
    } vec_t;

    vec_t vecs[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic s, input logic o, input logic l,
                                input logic [3:0] p, input logic c, input logic ed,
                                input logic [7:0] ec, input logic [3:0] ep);
        vec_t t;
        t.valid = v; t.seq = s; t.ovl = o; t.load = l; t.pat = p; t.clr = c;
        t.e_det = ed; t.e_cnt = ec; t.e_pat = ep;
        vecs.push_back(t);
    endfunction

    task automatic drive(input logic v, input logic s, input logic o, input logic l,
                         input logic [3:0] p, input logic c);
        valid_in = v; sequence_in = s; overlap_en = o;
        pattern_load = l; pattern_in = p; count_clear = c;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       stream[200];
        logic [7:0] pat8;
        logic [12:0] dbl;
        logic [6:0] m_hist;
        int         m_fill, m_cnt, idx, cyc;
        logic       v, s, m_match, ovl;

        // ---------------- vector table (instance A, pattern 1011) ----------
        // Overlapping: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7.
        add(1,1,1,0,4'h0,0, 0,0,4'b1011);
        add(1,0,1,0,4'h0,0, 0,0,4'b1011);
        add(1,1,1,0,4'h0,0, 0,0,4'b1011);
        add(1,1,1,0,4'h0,0, 1,1,4'b1011);
        add(1,0,1,0,4'h0,0, 0,1,4'b1011);
        add(1,1,1,0,4'h0,0, 0,1,4'b1011);
        add(1,1,1,0,4'h0,0, 1,2,4'b1011);
        // Reload same pattern (clears fill) and clear count.
        add(0,0,0,1,4'b1011,1, 0,0,4'b1011);
        // Non-overlapping: same stream -> single pulse after bit 4.
        add(1,1,0,0,4'h0,0, 0,0,4'b1011);
        add(1,0,0,0,4'h0,0, 0,0,4'b1011);
        add(1,1,0,0,4'h0,0, 0,0,4'b1011);
        add(1,1,0,0,4'h0,0, 1,1,4'b1011);
        add(1,0,0,0,4'h0,0, 0,1,4'b1011);
        add(1,1,0,0,4'h0,0, 0,1,4'b1011);
        add(1,1,0,0,4'h0,0, 0,1,4'b1011);
        // Valid gaps: 1,0,1,1 with three idle cycles between bits.
        add(0,0,1,1,4'b1011,1, 0,0,4'b1011);
        add(1,1,1,0,4'h0,0, 0,0,4'b1011);
        for (int i = 0; i < 3; i++) add(0,1,1,0,4'h0,0, 0,0,4'b1011);
        add(1,0,1,0,4'h0,0, 0,0,4'b1011);
        for (int i = 0; i < 3; i++) add(0,1,1,0,4'h0,0, 0,0,4'b1011);
        add(1,1,1,0,4'h0,0, 0,0,4'b1011);
        for (int i = 0; i < 3; i++) add(0,1,1,0,4'h0,0, 0,0,4'b1011);
        add(1,1,1,0,4'h0,0, 1,1,4'b1011);
        add(0,1,1,0,4'h0,0, 0,1,4'b1011);
        // Run-time load of 0110 while history holds 1,0,1; bit on load edge dropped.
        add(0,0,1,1,4'b1011,0, 0,1,4'b1011);
        add(1,1,1,0,4'h0,0, 0,1,4'b1011);
        add(1,0,1,0,4'h0,0, 0,1,4'b1011);
        add(1,1,1,0,4'h0,0, 0,1,4'b1011);
        add(1,1,1,1,4'b0110,0, 0,1,4'b0110);
        add(1,1,1,0,4'h0,0, 0,1,4'b0110);
        add(1,0,1,0,4'h0,0, 0,1,4'b0110);
        add(1,1,1,0,4'h0,0, 0,1,4'b0110);
        add(1,1,1,0,4'h0,0, 0,1,4'b0110);
        add(1,0,1,0,4'h0,0, 1,2,4'b0110);
        // Load edge with a bit that would complete 0110: must not match.
        add(0,0,1,1,4'b0110,0, 0,2,4'b0110);
        add(1,0,1,0,4'h0,0, 0,2,4'b0110);
        add(1,1,1,0,4'h0,0, 0,2,4'b0110);
        add(1,1,1,0,4'h0,0, 0,2,4'b0110);
        add(1,0,1,1,4'b0110,0, 0,2,4'b0110);
        add(1,0,1,0,4'h0,0, 0,2,4'b0110);
        // count_clear alone.
        add(0,0,1,0,4'h0,1, 0,0,4'b0110);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(0,0,1,0,4'h0,0);
        pattern_in_c = 8'h00;
        #12;
        check("reset a_det", 32'(a_det), 32'd0);
        check("reset a_cnt", 32'(a_cnt), 32'd0);
        check("reset a_sat", 32'(a_sat), 32'd0);
        check("reset a_pat", 32'(a_pat), 32'hB);
        check("reset b_sat", 32'(b_sat), 32'd0);
        check("reset c_pat", 32'(c_pat), 32'hA5);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].seq, vecs[i].ovl, vecs[i].load, vecs[i].pat, vecs[i].clr);
            step();
            check($sformatf("vec%0d det", i), 32'(a_det), 32'(vecs[i].e_det));
            check($sformatf("vec%0d cnt", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d pat", i), 32'(a_pat), 32'(vecs[i].e_pat));
        end

        // ---------------- saturation (instance B, CNT_W=2) ----------------
        drive(0,0,1,1,4'b1111,1);
        step();
        check("sat load b_pat", 32'(b_pat), 32'hF);
        check("sat load b_cnt", 32'(b_cnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            int ec;
            ec = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            drive(1,1,1,0,4'b1111,0);
            step();
            check($sformatf("sat%0d b_det", i), 32'(b_det), 32'(i >= 3));
            check($sformatf("sat%0d b_cnt", i), 32'(b_cnt), 32'(ec));
            check($sformatf("sat%0d b_sat", i), 32'(b_sat), 32'(ec == 3));
        end
        check("sat a_cnt", 32'(a_cnt), 32'd7);
        drive(1,1,1,0,4'b1111,1);
        step();
        check("clr+match b_det", 32'(b_det), 32'd1);
        check("clr+match b_cnt", 32'(b_cnt), 32'd1);
        check("clr+match b_sat", 32'(b_sat), 32'd0);
        check("clr+match a_cnt", 32'(a_cnt), 32'd1);

        // ---------------- asynchronous reset mid-pattern ----------------
        drive(0,0,1,1,4'b1111,0);
        step();
        drive(1,1,1,0,4'h0,0); step();
        drive(1,0,1,0,4'h0,0); step();
        drive(1,1,1,0,4'h0,0); step();
        check("pre-reset a_cnt", 32'(a_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async a_det", 32'(a_det), 32'd0);
        check("async a_cnt", 32'(a_cnt), 32'd0);
        check("async a_sat", 32'(a_sat), 32'd0);
        check("async a_pat", 32'(a_pat), 32'hB);
        check("async b_cnt", 32'(b_cnt), 32'd0);
        drive(0,0,1,0,4'h0,0);
        step();
        check("held a_cnt", 32'(a_cnt), 32'd0);
        #3;
        rst_n = 1'b1;
        drive(1,1,1,0,4'h0,0); step();
        check("post-reset 1 a_det", 32'(a_det), 32'd0);
        drive(1,1,1,0,4'h0,0); step();
        check("post-reset 2 a_det", 32'(a_det), 32'd0);
        drive(1,0,1,0,4'h0,0); step();
        check("post-reset 3 a_det", 32'(a_det), 32'd0);
        drive(1,1,1,0,4'h0,0); step();
        check("post-reset 4 a_det", 32'(a_det), 32'd0);
        drive(1,1,1,0,4'h0,0); step();
        check("post-reset 5 a_det", 32'(a_det), 32'd1);
        check("post-reset 5 a_cnt", 32'(a_cnt), 32'd1);
        drive(0,0,1,0,4'h0,0); step();
        check("post-reset 6 a_det", 32'(a_det), 32'd0);

        // ---------------- generic width (instance C, 8'hA5) ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("gen reset c_pat", 32'(c_pat), 32'hA5);
        check("gen reset c_cnt", 32'(c_cnt), 32'd0);
        pat8 = 8'hA5;
        dbl  = 13'b1010010100101;
        for (int i = 0; i < 200; i++) stream[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            stream[20 + i]  = pat8[7 - i];
            stream[60 + i]  = pat8[7 - i];
            stream[120 + i] = pat8[7 - i];
            stream[190 + i] = pat8[7 - i];
        end
        for (int i = 0; i < 13; i++) stream[150 + i] = dbl[12 - i];

        m_hist = '0;
        m_fill = 0;
        m_cnt  = 0;
        for (int pass = 0; pass < 2; pass++) begin
            ovl = (pass == 0);
            idx = 0;
            cyc = 0;
            while (idx < 200 && cyc < 2000) begin
                v = ($urandom_range(0, 7) != 0);
                s = v ? stream[idx] : 1'($urandom_range(0, 1));
                m_match = v && ({m_hist, s} == 8'hA5) && (m_fill >= 7);
                drive(v, s, ovl, 0, 4'h0, 0);
                step();
                check($sformatf("gen p%0d c%0d det", pass, cyc), 32'(c_det), 32'(m_match));
                if (m_match) m_cnt++;
                check($sformatf("gen p%0d c%0d cnt", pass, cyc), 32'(c_cnt), 32'(m_cnt));
                if (v) begin
                    m_hist = {m_hist[5:0], s};
                    if (m_match && !ovl) m_fill = 0;
                    else if (m_fill < 7) m_fill++;
                    idx++;
                end
                cyc++;
            end
            check($sformatf("gen p%0d stream consumed", pass), 32'(idx), 32'd200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the successor to the fixed-pattern sequence detector. It samples one qualified bit per clock and compares the last PATTERN_W accepted bits against a run-time-loadable pattern. It pulses detector_out on each match and keeps a saturating match count. Overlapping or non-overlapping detection is selected at run time. It sits on a serial bit stream behind a deserialiser or line decoder and feeds control or statistics logic.

## Interface

Parameters:

- PATTERN_W, 4: pattern length in bits; legal range 2..32.
- RESET_PATTERN, 4'b1011: pattern loaded at reset; width PATTERN_W, MSB = oldest bit.
- CNT_W, 8: match counter width; legal range 1..32.

Ports:

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 resets all state.
- sequence_in  in  1  serial data bit.
- valid_in  in  1  sequence_in is accepted on this edge only when 1.
- overlap_en  in  1  1 selects overlapping detection; 0 selects non-overlapping.
- pattern_load  in  1  loads pattern_in on this edge.
- pattern_in  in  PATTERN_W  new pattern; MSB = first/oldest bit.
- count_clear  in  1  clears match_count.
- detector_out  out  1  registered single-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- count_sat  out  1  high while match_count equals 2^CNT_W-1.
- pattern_out  out  PATTERN_W  currently active pattern.

## Operation

- State:
  - history register (PATTERN_W-1 bits): previous accepted bits.
  - fill counter (0..PATTERN_W-1, saturating): number of valid history bits.
  - pattern register, match counter, detector_out flop.
- Accepted bit: valid_in=1 and pattern_load=0 at the rising edge.
- Window: {history, sequence_in}; sequence_in is the LSB / newest bit.
- Match condition: the bit is accepted, the window equals the pattern register, and fill = PATTERN_W-1.
- On an accepted bit:
  - history shifts left with sequence_in entering the LSB.
  - Overlap mode, or no match: fill increments, saturating at PATTERN_W-1.
  - Non-overlap mode with a match: fill clears to 0, so the matched bits cannot contribute to the next match.
- valid_in=0: history, fill and counter hold; detector_out goes 0 on that edge.
- pattern_load=1:
  - pattern register takes pattern_in and fill clears to 0.
  - Any bit presented on the same edge is dropped and no match is evaluated.
- overlap_en may change on any cycle; it applies to the edge on which it is sampled.
- Match counter:
  - +1 per match, saturating at 2^CNT_W-1; it never wraps.
  - count_clear alone sets it to 0.
  - count_clear together with a match sets it to 1.
- Reset (asserted asynchronously at any time, including mid-pattern):
  - history=0, fill=0, pattern=RESET_PATTERN, match_count=0.
  - detector_out=0, count_sat=0, pattern_out=RESET_PATTERN.
  - A partial match in progress is discarded.

## Timing

- Latency: detector_out is high for exactly the one cycle after the edge that accepted the final pattern bit.
- Back-to-back matches: in overlap mode a periodic pattern can produce pulses on consecutive cycles, e.g. all-ones pattern with a continuous stream of 1s.
- match_count and count_sat update on the same edge as detector_out.
- pattern_out reflects a load one cycle after the pattern_load edge.
- No combinational path from any input to any output; all outputs are registered.
- Reset release: the first edge after reset rises may accept a bit. The earliest possible match is on the PATTERN_W-th accepted bit.

## Test plan

- **Overlap vs non-overlap:** defaults, stream 1,0,1,1,0,1,1 with valid_in=1 throughout.
  - overlap_en=1: detector_out pulses after bits 4 and 7; match_count=2.
  - overlap_en=0: single pulse after bit 4; match_count=1.
- **Valid gaps:** stream 1,0,1,1 with valid_in=0 for 3 cycles between each bit -> exactly one pulse, one cycle after the 4th accepted bit; no pulse during the gaps.
- **Run-time load:**
  - pattern_load with pattern_in=4'b0110 while history holds 1,0,1 -> pattern_out=0110 next cycle.
  - Then feed 1 -> no match, since fill was cleared.
  - Then feed 0,1,1,0 -> one pulse.
  - A bit presented on the load edge must be ignored.
- **Saturation and clear:**
  - CNT_W=2, all-ones pattern, overlap, 10 consecutive 1s -> match_count stops at 3 with count_sat=1.
  - count_clear coincident with a match -> match_count=1, count_sat=0.
- **Asynchronous reset mid-pattern:**
  - Feed 1,0,1, assert reset between clock edges -> outputs reset immediately without waiting for an edge.
  - Release and feed 1 -> no match.
  - Then 1,0,1,1 -> one pulse.
- **Generic width:** PATTERN_W=8, RESET_PATTERN=8'hA5, random 200-bit stream -> pulse count and positions match a software reference model in both modes.
